// File: rtl/sub_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial_if
// Description : Handshake/operand bundle for the bit-serial subtractor.
//               The controller (master) drives the start/ack strobe and the
//               operands; the subtractor (slave) returns the registered
//               difference, the final borrow and the busy/done status.
//   en     : start request in IDLE, acknowledge in DONE        (master -> slave)
//   a, b   : minuend / subtrahend, sampled on the start edge   (master -> slave)
//   out    : registered difference (a - b) mod 2^WIDTH         (slave -> master)
//   borrow : registered final borrow, 1 when a < b unsigned    (slave -> master)
//   busy   : operation in progress                             (slave -> master)
//   done   : result valid and held until acknowledged          (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface sub_serial_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] out;
   logic             borrow;
   logic             busy;
   logic             done;

   // Controller side.
   modport master (
      output en,
      output a,
      output b,
      input  out,
      input  borrow,
      input  busy,
      input  done
   );

   // Subtractor side.
   modport slave (
      input  en,
      input  a,
      input  b,
      output out,
      output borrow,
      output busy,
      output done
   );
endinterface : sub_serial_if
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial
// Description : Bit-serial unsigned subtractor, out = a - b (mod 2^WIDTH),
//               one bit per clock LSB first through a single full-subtractor
//               cell, with a registered final borrow. Control is IDLE -> SUB
//               (WIDTH cycles) -> DONE, started and acknowledged with en, so it
//               is interchangeable with the bit-serial adder of the library.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset, clears every register
//               bus  - sub_serial_if.slave (en, a, b in; out, borrow, busy,
//                      done out)
// Revision    : 1.0 - initial release
// ============================================================================
module sub_serial #(
   parameter int WIDTH = 8
) (
   input  wire logic   clk,
   input  wire logic   rst,
   sub_serial_if.slave bus
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;   // waiting for en
   localparam logic [1:0] SUB  = 2'd1;   // shifting / subtracting
   localparam logic [1:0] DONE = 2'd2;   // result held until acknowledged

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // A one-bit operand would make the shift/count logic degenerate.
   generate
      if (WIDTH < 2) begin : g_width_check
         $error("sub_serial: WIDTH must be at least 2");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Registers (<sig>_q) and their next values (<sig>_d)
   // -------------------------------------------------------------------------
   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_reg_q,  a_reg_d;
   logic [WIDTH-1:0] b_reg_q,  b_reg_d;
   logic [WIDTH-1:0] out_q,    out_d;
   logic             bw_q,     bw_d;       // running borrow between bit slices
   logic             borrow_q, borrow_d;   // borrow out of the MSB slice
   logic [CNT_W-1:0] count_q,  count_d;

   // -------------------------------------------------------------------------
   // Full-subtractor cell working on the current LSBs
   // -------------------------------------------------------------------------
   logic a_bit;
   logic b_bit;
   logic diff_bit;
   logic bw_next;
   logic last_slice;
   logic start;

   always_comb begin
      a_bit      = a_reg_q[0];
      b_bit      = b_reg_q[0];
      diff_bit   = a_bit ^ b_bit ^ bw_q;
      // Borrow out: either a plain 0-1, or equal bits that pass the
      // incoming borrow straight through.
      bw_next    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
      last_slice = (count_q == CNT_LAST);
      start      = (state_q == IDLE) && bus.en;
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.en) begin
               state_d = SUB;
            end
         end
         SUB: begin
            // en is deliberately ignored while the operation runs.
            if (last_slice) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.en) begin
               state_d = IDLE;
            end
         end
         default: begin
            // The unused encoding recovers to IDLE without touching data.
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs decoded from the state register
   // -------------------------------------------------------------------------
   always_comb begin
      bus.busy = (state_q == SUB);
      bus.done = (state_q == DONE);
   end

   // -------------------------------------------------------------------------
   // Datapath next-value logic
   // -------------------------------------------------------------------------
   always_comb begin
      a_reg_d  = a_reg_q;
      b_reg_d  = b_reg_q;
      out_d    = out_q;
      bw_d     = bw_q;
      borrow_d = borrow_q;
      count_d  = count_q;

      if (start) begin
         // Operands are only looked at on the start edge.
         a_reg_d  = bus.a;
         b_reg_d  = bus.b;
         out_d    = '0;
         bw_d     = 1'b0;
         borrow_d = 1'b0;
         count_d  = '0;
      end else if (state_q == SUB) begin
         // Each result bit enters at the MSB and walks down; after WIDTH
         // slices bit i has reached out[i].
         out_d   = {diff_bit, out_q[WIDTH-1:1]};
         a_reg_d = a_reg_q >> 1;
         b_reg_d = b_reg_q >> 1;
         bw_d    = bw_next;
         count_d = count_q + CNT_ONE;
         if (last_slice) begin
            borrow_d = bw_next;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg_q  <= '0;
         b_reg_q  <= '0;
         out_q    <= '0;
         bw_q     <= 1'b0;
         borrow_q <= 1'b0;
         count_q  <= '0;
      end else begin
         a_reg_q  <= a_reg_d;
         b_reg_q  <= b_reg_d;
         out_q    <= out_d;
         bw_q     <= bw_d;
         borrow_q <= borrow_d;
         count_q  <= count_d;
      end
   end

   // -------------------------------------------------------------------------
   // Result outputs
   // -------------------------------------------------------------------------
   assign bus.out    = out_q;
   assign bus.borrow = borrow_q;

endmodule : sub_serial
`default_nettype wire

// File: tb/tb_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_serial
// Description : Self-checking bench for sub_serial. A transaction-level model
//               (operation phase, remaining cycles, arithmetic result) is
//               compared with the DUT on every falling edge, and directed
//               vectors carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_serial;

   localparam int W = 8;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_err    = 0;

   sub_serial_if #(.WIDTH(W)) bus ();

   sub_serial #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Checker shared by the model compare and the directed vectors
   // ------------------------------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: phase 0 = idle, 1 = running, 2 = result held.
   // Result is plain modular subtraction and an unsigned compare.
   // ------------------------------------------------------------------
   int           m_phase;
   int           m_left;
   logic [W-1:0] m_exp;
   logic         m_ebor;
   logic [W-1:0] m_out;
   logic         m_borrow;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase  <= 0;
         m_left   <= 0;
         m_out    <= '0;
         m_borrow <= 1'b0;
      end else begin
         case (m_phase)
            0: if (bus.en) begin
                  m_exp   <= bus.a - bus.b;
                  m_ebor  <= (bus.a < bus.b);
                  m_left  <= W;
                  m_phase <= 1;
               end
            1: begin
                  m_left <= m_left - 1;
                  if (m_left == 1) begin
                     m_phase  <= 2;
                     m_out    <= m_exp;
                     m_borrow <= m_ebor;
                  end
               end
            default: if (bus.en) m_phase <= 0;
         endcase
      end
   end

   // Single compare process; out/borrow are meaningful outside the run.
   always @(negedge clk) begin
      if (!rst) begin
         chk("model_busy", bus.busy, (m_phase == 1));
         chk("model_done", bus.done, (m_phase == 2));
         if (m_phase != 1) begin
            chk("model_out",    bus.out,    m_out);
            chk("model_borrow", bus.borrow, m_borrow);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic ack_done();
      @(negedge clk); bus.en = 1'b1;
      @(negedge clk); bus.en = 1'b0;
      chk("ack_done_low", bus.done, 1'b0);
      chk("ack_busy_low", bus.busy, 1'b0);
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] xo, input logic xb,
                         input bit jam, input bit ack);
      int busy_cyc;
      int waited;
      @(negedge clk);
      bus.a  = ta;
      bus.b  = tb_v;
      bus.en = 1'b1;
      @(negedge clk);
      bus.en   = 1'b0;
      busy_cyc = 0;
      waited   = 0;
      while (!bus.done && waited < 20) begin
         if (bus.busy) busy_cyc++;
         if (jam) begin
            bus.a  = W'($urandom);
            bus.b  = W'($urandom);
            bus.en = ~bus.en;
         end
         @(negedge clk);
         waited++;
      end
      bus.en = 1'b0;
      chk("op_done_reached", bus.done, 1'b1);
      chk("op_busy_cycles", busy_cyc, W);
      chk("op_out", bus.out, xo);
      chk("op_borrow", bus.borrow, xb);
      if (ack) ack_done();
   endtask

   // Bring the block back to IDLE from wherever it is, with en low.
   task automatic go_idle();
      int waited;
      bus.en = 1'b0;
      waited = 0;
      @(negedge clk);
      while (bus.busy && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("go_idle_not_busy", bus.busy, 1'b0);
      if (bus.done) ack_done();
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      int last_rise;
      int dur;
      int rises;
      logic prev_done;

      rst    = 1'b1;
      bus.en = 1'b0;
      bus.a  = '0;
      bus.b  = '0;
      #12;
      chk("rst_out",    bus.out,    8'h00);
      chk("rst_borrow", bus.borrow, 1'b0);
      chk("rst_busy",   bus.busy,   1'b0);
      chk("rst_done",   bus.done,   1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Basic and underflow / edge operands
      run_op(8'd100, 8'd37,  8'd63,  1'b0, 1'b0, 1'b1);
      run_op(8'd5,   8'd7,   8'hFE,  1'b1, 1'b0, 1'b1);
      run_op(8'd0,   8'd1,   8'hFF,  1'b1, 1'b0, 1'b1);
      run_op(8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0, 1'b1);
      run_op(8'hFF,  8'h00,  8'hFF,  1'b0, 1'b0, 1'b1);
      run_op(8'h00,  8'h80,  8'h80,  1'b1, 1'b0, 1'b1);

      // Operand / en isolation while running
      run_op(8'd200, 8'd55,  8'd145, 1'b0, 1'b1, 1'b1);

      // DONE held for 10 cycles with en low
      run_op(8'd10,  8'd3,   8'd7,   1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_done",   bus.done,   1'b1);
         chk("hold_out",    bus.out,    8'd7);
         chk("hold_borrow", bus.borrow, 1'b0);
      end
      ack_done();

      // en held high: period WIDTH+2, one-cycle done
      @(negedge clk);
      bus.a     = 8'd50;
      bus.b     = 8'd20;
      bus.en    = 1'b1;
      last_rise = -1;
      dur       = 0;
      rises     = 0;
      prev_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done) begin
            dur++;
            if (!prev_done) begin
               rises++;
               if (last_rise >= 0) chk("cont_period", c - last_rise, W + 2);
               last_rise = c;
               chk("cont_out", bus.out, 8'd30);
            end
         end else if (prev_done) begin
            chk("cont_done_width", dur, 1);
            dur = 0;
         end
         prev_done = bus.done;
      end
      chk("cont_rises", (rises >= 3), 1'b1);
      go_idle();

      // Asynchronous reset in the middle of an operation (count = 3)
      @(negedge clk);
      bus.a  = 8'd100;
      bus.b  = 8'd37;
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      chk("pre_rst_busy", bus.busy, 1'b1);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out",    bus.out,    8'h00);
      chk("async_rst_borrow", bus.borrow, 1'b0);
      chk("async_rst_busy",   bus.busy,   1'b0);
      chk("async_rst_done",   bus.done,   1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle_busy", bus.busy, 1'b0);
      chk("post_rst_idle_done", bus.done, 1'b0);
      run_op(8'd9,   8'd200, 8'd65,  1'b1, 1'b0, 1'b1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_sub_serial
`default_nettype wire
